cla_pipe_addsub: RTL and testbench
==================================

// Module: cla_pipe_addsub
// PURPOSE
//  Parametrised, 3-stage pipelined hierarchical carry-lookahead adder/subtractor.
//  Successor to the fixed 16-bit CLA: generic width and lookahead block size, add/sub mode, status flags.
//  Uses a valid/ready stream handshake with full backpressure.
//  Feeds the datapath ALU and the address-generation units.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of BLK
//  BLK    4   bits per lookahead block; block count NB = WIDTH/BLK
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand beat
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub, active-high)
//  sub        in   1      0: A+B+cin; 1: A-B-cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of the MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  Reset: all stage valids 0, out_valid=0, sum/cout/ovf/zero=0. in_ready=1 from the first cycle after reset.
//  Reset mid-operation discards all in-flight beats; nothing is emitted afterwards.
//  Arithmetic: b_eff = sub ? ~b : b; c0 = cin ^ sub.
//   sum = (a + b_eff + c0) mod 2^WIDTH; cout = bit WIDTH of that sum.
//   ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); zero = ~|sum.
//  S1 (capture): register p = a^b_eff, g = a&b_eff, c0, a[MSB], b_eff[MSB].
//  S2 (block lookahead): per block compute Pblk = &p[blk] and Gblk = standard 4-term group generate.
//   Then the block-carry chain: C[0]=c0; C[k+1] = Gblk[k] | Pblk[k]&C[k]; cout = C[NB].
//   Register C[NB-1:0], cout, p, g, MSB info.
//  S3 (sum): within each block, in-block lookahead carries from C[k]; sum = p ^ carries.
//   Register sum/cout/ovf/zero and drive the output ports directly from the S3 registers.
//  Latency: 3 cycles, in-handshake to out_valid, with no stall. Throughput: 1 beat/cycle.
//  Handshake:
//   - Input beat transfers when in_valid & in_ready; output when out_valid & out_ready.
//   - Stage k loads when !v_k || adv_{k+1}. adv_4 = out_ready. in_ready = !v1 || adv_2.
//   - A stalled stage holds its data and valid unchanged. Outputs stay stable while out_valid & !out_ready.
//   - A stage that empties without an incoming beat clears valid; its data regs may hold stale values.
//   - Full pipe with out_ready=0: in_ready=0; 3 beats held, none lost or duplicated.
//   - Simultaneous accept and emit on a full pipe is allowed (no bubble).
//   - in_valid with in_ready=0 is a no-op; the source must hold its beat (AXI-stream rules).
//  Beats emerge in order. No combinational path from in_valid/a/b to any output.
//   in_ready depends combinationally on out_ready only.
// TESTING (WIDTH=32, BLK=4 unless noted)
//  1 Add carry ripple across all blocks:
//    a=FFFF_FFFF, b=0000_0001, cin=0, sub=0 -> sum=0, cout=1, zero=1, ovf=0, out_valid exactly 3 cycles after accept.
//  2 Signed overflow:
//    a=7FFF_FFFF, b=1, add -> sum=8000_0000, ovf=1, cout=0.
//    a=0000_0005, b=0000_0007, sub=1, cin=0 -> sum=FFFF_FFFE, cout=0, ovf=0.
//  3 Borrow-in: a=10, b=3, sub=1, cin=1 -> sum=6, cout=1.
//  4 Backpressure:
//    Stream 8 beats (a=i, b=i); hold out_ready=0 for 6 cycles.
//    -> in_ready drops after 3 accepts; then all 8 results 2i emerge in order, no loss.
//  5 Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 and outputs 0 immediately.
//    After release, no stale beat is emitted.
//  6 Random: 10k random a/b/cin/sub with random valid/ready, at WIDTH=16,BLK=4 and WIDTH=64,BLK=8.
//    Scoreboard against a behavioural +/- model.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Three-stage pipelined hierarchical carry-lookahead adder/subtractor with
// valid/ready handshaking on both sides and full backpressure.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NB = WIDTH / BLK;

    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    // A stage may take a new beat when it is empty or its content moves on.
    assign load3    = !v3_q || out_ready;
    assign load2    = !v2_q || load3;
    assign load1    = !v1_q || load2;
    assign in_ready = load1;

    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] p1_d, g1_d;
    logic [WIDTH-1:0] p1_q, g1_q;
    logic             c01_q, aMsb1_q, bMsb1_q;

    assign bEff = sub ? ~b : b;
    assign p1_d = a ^ bEff;
    assign g1_d = a & bEff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            p1_q    <= '0;
            g1_q    <= '0;
            c01_q   <= 1'b0;
            aMsb1_q <= 1'b0;
            bMsb1_q <= 1'b0;
        end else begin
            if (load1) begin
                v1_q <= in_valid;
            end
            if (load1 && in_valid) begin
                p1_q    <= p1_d;
                g1_q    <= g1_d;
                c01_q   <= cin ^ sub;
                aMsb1_q <= a[WIDTH-1];
                bMsb1_q <= bEff[WIDTH-1];
            end
        end
    end

    logic [NB-1:0] blkC2_d;
    logic          cout2_d;

    // Group propagate/generate per block, then the block-level carry chain.
    always_comb begin
        logic pk, gk, pRun, cRun;
        blkC2_d = '0;
        pk      = 1'b0;
        gk      = 1'b0;
        pRun    = 1'b0;
        cRun    = c01_q;
        for (int k = 0; k < NB; k++) begin
            pk   = &p1_q[k*BLK +: BLK];
            gk   = 1'b0;
            pRun = 1'b1;
            for (int i = BLK - 1; i >= 0; i--) begin
                gk   = gk | (pRun & g1_q[k*BLK + i]);
                pRun = pRun & p1_q[k*BLK + i];
            end
            blkC2_d[k] = cRun;
            cRun       = gk | (pk & cRun);
        end
        cout2_d = cRun;
    end

    logic [NB-1:0]    blkC2_q;
    logic             cout2_q, aMsb2_q, bMsb2_q;
    logic [WIDTH-1:0] p2_q, g2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            blkC2_q <= '0;
            cout2_q <= 1'b0;
            p2_q    <= '0;
            g2_q    <= '0;
            aMsb2_q <= 1'b0;
            bMsb2_q <= 1'b0;
        end else begin
            if (load2) begin
                v2_q <= v1_q;
            end
            if (load2 && v1_q) begin
                blkC2_q <= blkC2_d;
                cout2_q <= cout2_d;
                p2_q    <= p1_q;
                g2_q    <= g1_q;
                aMsb2_q <= aMsb1_q;
                bMsb2_q <= bMsb1_q;
            end
        end
    end

    logic [WIDTH-1:0] sum3_d;
    logic             ovf3_d, zero3_d;

    // Each bit's carry is a flat sum-of-products back to its block carry-in.
    always_comb begin
        logic acc, pRun;
        sum3_d = '0;
        acc    = 1'b0;
        pRun   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < BLK; j++) begin
                acc  = 1'b0;
                pRun = 1'b1;
                for (int i = j - 1; i >= 0; i--) begin
                    acc  = acc | (pRun & g2_q[k*BLK + i]);
                    pRun = pRun & p2_q[k*BLK + i];
                end
                acc = acc | (pRun & blkC2_q[k]);
                sum3_d[k*BLK + j] = p2_q[k*BLK + j] ^ acc;
            end
        end
    end

    assign ovf3_d  = (aMsb2_q == bMsb2_q) && (sum3_d[WIDTH-1] != aMsb2_q);
    assign zero3_d = ~|sum3_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (load3) begin
                v3_q <= v2_q;
            end
            if (load3 && v2_q) begin
                sum_q  <= sum3_d;
                cout_q <= cout2_q;
                ovf_q  <= ovf3_d;
                zero_q <= zero3_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three widths driven in lockstep, each scored
// against a plain-arithmetic add/subtract model.
module tb_cla_pipe_addsub;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        outReady;
    logic        cin;
    logic        sub;
    logic [63:0] aIn;
    logic [63:0] bIn;

    logic        inReady16, outValid16, cout16, ovf16, zero16;
    logic [15:0] sum16;
    logic        inReady32, outValid32, cout32, ovf32, zero32;
    logic [31:0] sum32;
    logic        inReady64, outValid64, cout64, ovf64, zero64;
    logic [63:0] sum64;

    int testsRun  = 0;
    int failCount = 0;

    logic [66:0] q16[$];
    logic [66:0] q32[$];
    logic [66:0] q64[$];

    cla_pipe_addsub #(.WIDTH(16), .BLK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady16),
        .a(aIn[15:0]), .b(bIn[15:0]), .cin(cin), .sub(sub),
        .out_valid(outValid16), .out_ready(outReady), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    cla_pipe_addsub #(.WIDTH(32), .BLK(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady32),
        .a(aIn[31:0]), .b(bIn[31:0]), .cin(cin), .sub(sub),
        .out_valid(outValid32), .out_ready(outReady), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    cla_pipe_addsub #(.WIDTH(64), .BLK(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady64),
        .a(aIn), .b(bIn), .cin(cin), .sub(sub),
        .out_valid(outValid64), .out_ready(outReady), .sum(sum64),
        .cout(cout64), .ovf(ovf64), .zero(zero64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Result packed as {cout, ovf, zero, sum}, computed from unsigned and
    // signed interpretations of the operands rather than bit-level carries.
    function automatic logic [66:0] refModel(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic c,
                                             input logic s);
        logic [67:0]        ua, ub, uc, ur;
        logic signed [67:0] sa, sb, sc, sr, sMax, sMin;
        logic [63:0]        mask, res;
        logic               co, ov;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ua = {4'b0, a & mask};
        ub = {4'b0, b & mask};
        uc = {67'b0, c};
        sa = ua;
        sb = ub;
        sc = uc;
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        sMax = (68'sd1 <<< (w - 1)) - 68'sd1;
        sMin = -(68'sd1 <<< (w - 1));
        if (s) begin
            ur = ua - ub - uc;
            co = (ua >= ub + uc);
            sr = sa - sb - sc;
        end else begin
            ur = ua + ub + uc;
            co = ((ur >> w) != 68'd0);
            sr = sa + sb + sc;
        end
        res = ur[63:0] & mask;
        ov  = (sr > sMax) || (sr < sMin);
        return {co, ov, (res == 64'd0), res};
    endfunction

    // Scoreboard: enqueue on every accepted beat, dequeue and compare on every
    // emitted beat; a reset throws away everything that was in flight.
    always @(negedge clk) begin
        logic [66:0] exp;
        #1;
        if (!rst_n) begin
            q16.delete();
            q32.delete();
            q64.delete();
        end else begin
            if (outValid16 && outReady) begin
                if (q16.size() == 0) checkOutput("dut16 spurious beat", 64'd1, 64'd0);
                else begin
                    exp = q16.pop_front();
                    checkOutput("dut16 sum", 64'(sum16), exp[63:0]);
                    checkOutput("dut16 flags", {61'b0, cout16, ovf16, zero16}, {61'b0, exp[66:64]});
                end
            end
            if (outValid32 && outReady) begin
                if (q32.size() == 0) checkOutput("dut32 spurious beat", 64'd1, 64'd0);
                else begin
                    exp = q32.pop_front();
                    checkOutput("dut32 sum", 64'(sum32), exp[63:0]);
                    checkOutput("dut32 flags", {61'b0, cout32, ovf32, zero32}, {61'b0, exp[66:64]});
                end
            end
            if (outValid64 && outReady) begin
                if (q64.size() == 0) checkOutput("dut64 spurious beat", 64'd1, 64'd0);
                else begin
                    exp = q64.pop_front();
                    checkOutput("dut64 sum", sum64, exp[63:0]);
                    checkOutput("dut64 flags", {61'b0, cout64, ovf64, zero64}, {61'b0, exp[66:64]});
                end
            end
            if (inValid && inReady16) q16.push_back(refModel(16, aIn, bIn, cin, sub));
            if (inValid && inReady32) q32.push_back(refModel(32, aIn, bIn, cin, sub));
            if (inValid && inReady64) q64.push_back(refModel(64, aIn, bIn, cin, sub));
        end
    end

    // Present one beat and return just after the edge that transfers it.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        aIn     = a;
        bIn     = b;
        cin     = c;
        sub     = s;
        inValid = 1'b1;
        #1;
        while (!inReady32 && waitCycles < 50) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        if (!inReady32) checkOutput("accept timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic runDirected(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic c, input logic s, input logic [31:0] expSum,
                               input logic expCout, input logic expOvf, input logic expZero);
        int lat;
        applyStimulus(a, b, c, s);
        lat = 1;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        while (!outValid32 && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd3);
        checkOutput({tag, " sum"}, 64'(sum32), 64'(expSum));
        checkOutput({tag, " cout"}, 64'(cout32), 64'(expCout));
        checkOutput({tag, " ovf"}, 64'(ovf32), 64'(expOvf));
        checkOutput({tag, " zero"}, 64'(zero32), 64'(expZero));
        @(posedge clk);
    endtask

    function automatic logic [63:0] randWord();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h7FFF_7FFF_7FFF_7FFF;
            3:       return 64'h8000_8000_8000_8000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        int sent;
        logic holding;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        cin      = 1'b0;
        sub      = 1'b0;
        aIn      = '0;
        bIn      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset out_valid", 64'(outValid32), 64'd0);
        checkOutput("reset sum", 64'(sum32), 64'd0);
        checkOutput("reset flags", {61'b0, cout32, ovf32, zero32}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("in_ready after reset", 64'(inReady32), 64'd1);

        runDirected("ripple", 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        runDirected("ovf add", 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        runDirected("sub neg", 64'h5, 64'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runDirected("borrow in", 64'd10, 64'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0);

        // Backpressure: eight beats a=b=i with the sink stalled for six cycles.
        sent = 0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || q32.size() != 0); cyc++) begin
            @(negedge clk);
            outReady = (cyc >= 6);
            inValid  = (sent < 8);
            aIn      = 64'(sent);
            bIn      = 64'(sent);
            cin      = 1'b0;
            sub      = 1'b0;
            #1;
            if (cyc == 3) checkOutput("bp in_ready full", 64'(inReady32), 64'd0);
            if (cyc >= 3 && cyc < 6) begin
                checkOutput("bp hold valid", 64'(outValid32), 64'd1);
                checkOutput("bp hold sum", 64'(sum32), 64'd0);
            end
            if (cyc == 5) checkOutput("bp accepts while stalled", 64'(sent), 64'd3);
            if (inValid && inReady32) sent++;
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("bp beats sent", 64'(sent), 64'd8);
        checkOutput("bp all results out", 64'(q32.size()), 64'd0);

        // Reset with two beats in flight.
        applyStimulus(64'd100, 64'd1, 1'b0, 1'b0);
        applyStimulus(64'd200, 64'd2, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 64'(outValid32), 64'd0);
        checkOutput("mid reset sum", 64'(sum32), 64'd0);
        checkOutput("mid reset flags", {61'b0, cout32, ovf32, zero32}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput("post reset no stale beat", 64'(outValid32), 64'd0);
        end

        // Random traffic with random valid/ready; the source holds a refused beat.
        sent    = 0;
        holding = 1'b0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            @(negedge clk);
            if (!holding) begin
                inValid = ($urandom_range(0, 3) != 0);
                aIn     = randWord();
                bIn     = randWord();
                cin     = 1'($urandom_range(0, 1));
                sub     = 1'($urandom_range(0, 1));
            end
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            holding = inValid && !inReady32;
            if (inValid && inReady32) sent++;
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("random beats sent", 64'(sent), 64'd10000);
        checkOutput("random drain 16", 64'(q16.size()), 64'd0);
        checkOutput("random drain 32", 64'(q32.size()), 64'd0);
        checkOutput("random drain 64", 64'(q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
